// File: rtl/gray_bin_vector.sv
// rtl/gray_bin_vector.sv - combinational Gray-to-binary converter
module gray_bin_vector #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of the Gray bits at and above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - up/down counter with registered binary and Gray outputs
module gray_updown_counter #(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_g,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_q;
    logic             wrapped_q;
    logic [WIDTH-1:0] load_b;
    logic [WIDTH-1:0] b_next;
    logic             wrapped_next;

    gray_bin_vector #(
        .WIDTH(WIDTH)
    ) u_load_conv (
        .gray(load_g),
        .bin (load_b)
    );

    assign tc = up ? (b_q == MAX_COUNT) : (b_q == '0);

    always_comb begin
        b_next       = b_q;
        wrapped_next = 1'b0;
        if (load) begin
            b_next = load_b;
        end else if (en) begin
            if (tc) begin
                // At a limit: either roll over or stick, flagging the event both ways.
                wrapped_next = 1'b1;
                if (WRAP != 0) begin
                    b_next = up ? '0 : MAX_COUNT;
                end
            end else begin
                b_next = up ? (b_q + ONE) : (b_q - ONE);
            end
        end
    end

    // g is registered from the same next value so it never lags or glitches against b.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q       <= '0;
            g_q       <= '0;
            wrapped_q <= 1'b0;
        end else begin
            b_q       <= b_next;
            g_q       <= b_next ^ (b_next >> 1);
            wrapped_q <= wrapped_next;
        end
    end

    assign b       = b_q;
    assign g       = g_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed and randomised checks of gray_updown_counter
module tb_gray_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a: WIDTH=3, wrapping
    logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [2:0] a_load_g = '0;
    logic [2:0] a_b, a_g;
    logic       a_tc, a_wrapped;

    // Instance s: WIDTH=3, saturating
    logic       s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_load = 1'b0;
    logic [2:0] s_load_g = '0;
    logic [2:0] s_b, s_g;
    logic       s_tc, s_wrapped;

    // Instance w: WIDTH=8, wrapping, random traffic
    logic       w_rst = 1'b1, w_en = 1'b0, w_up = 1'b1, w_load = 1'b0;
    logic [7:0] w_load_g = '0;
    logic [7:0] w_b, w_g;
    logic       w_tc, w_wrapped;

    gray_updown_counter #(.WIDTH(3), .WRAP(1)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_g(a_load_g),
        .b(a_b), .g(a_g), .tc(a_tc), .wrapped(a_wrapped)
    );

    gray_updown_counter #(.WIDTH(3), .WRAP(0)) dut_s (
        .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load), .load_g(s_load_g),
        .b(s_b), .g(s_g), .tc(s_tc), .wrapped(s_wrapped)
    );

    gray_updown_counter #(.WIDTH(8), .WRAP(1)) dut_w (
        .clk(clk), .rst(w_rst), .en(w_en), .up(w_up), .load(w_load), .load_g(w_load_g),
        .b(w_b), .g(w_g), .tc(w_tc), .wrapped(w_wrapped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gray_to_bin8(input logic [7:0] gv);
        logic [7:0] r;
        r[7] = gv[7];
        for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
        return r;
    endfunction

    logic [2:0] g_up_seq [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

    initial begin
        logic [7:0] mb, mb_next, prev_g;
        logic       exp_wr;

        // Reset all instances.
        tick();
        chk("a_reset_b", 32'(a_b), 32'd0);
        chk("a_reset_g", 32'(a_g), 32'd0);
        chk("a_reset_wrapped", 32'(a_wrapped), 32'd0);
        chk("a_reset_tc_up", 32'(a_tc), 32'd0);
        a_up = 1'b0;
        #1;
        chk("a_reset_tc_down", 32'(a_tc), 32'd1);
        a_up = 1'b1;
        a_rst = 1'b0;

        // Count up 9 steps through the wrap.
        a_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("a_up_g_%0d", k), 32'(a_g), 32'(g_up_seq[k-1]));
            chk($sformatf("a_up_b_%0d", k), 32'(a_b), 32'(k % 8));
            chk($sformatf("a_up_wr_%0d", k), 32'(a_wrapped), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("a_up_tc_%0d", k), 32'(a_tc), (k == 7) ? 32'd1 : 32'd0);
        end

        // From reset, one down step wraps to 7.
        a_en = 1'b0;
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_en = 1'b1;
        a_up = 1'b0;
        tick();
        chk("a_down_b", 32'(a_b), 32'd7);
        chk("a_down_g", 32'(a_g), 32'b100);
        chk("a_down_wr", 32'(a_wrapped), 32'd1);
        a_en = 1'b0;
        tick();
        chk("a_idle_b", 32'(a_b), 32'd7);
        chk("a_idle_wr", 32'(a_wrapped), 32'd0);

        // Load at terminal count with en high: load wins, no wrap flag.
        a_up = 1'b1;
        a_en = 1'b1;
        a_load = 1'b1;
        a_load_g = 3'b000;
        tick();
        chk("a_load_tc_b", 32'(a_b), 32'd0);
        chk("a_load_tc_wr", 32'(a_wrapped), 32'd0);

        // Load 110 with en=1, then one up step.
        a_load_g = 3'b110;
        tick();
        chk("a_load_b", 32'(a_b), 32'b100);
        chk("a_load_g", 32'(a_g), 32'b110);
        chk("a_load_wr", 32'(a_wrapped), 32'd0);
        a_load = 1'b0;
        tick();
        chk("a_after_load_g", 32'(a_g), 32'b111);
        chk("a_after_load_b", 32'(a_b), 32'd5);

        // Reset at b=5 together with load.
        a_load = 1'b1;
        a_load_g = 3'b011;
        a_rst = 1'b1;
        tick();
        chk("a_rst_load_b", 32'(a_b), 32'd0);
        chk("a_rst_load_g", 32'(a_g), 32'd0);
        chk("a_rst_load_wr", 32'(a_wrapped), 32'd0);
        a_rst = 1'b0;
        a_load = 1'b0;
        tick();
        chk("a_resume_b", 32'(a_b), 32'd1);
        a_up = 1'b0;
        tick();
        chk("a_dirchg_b", 32'(a_b), 32'd0);
        chk("a_dirchg_g", 32'(a_g), 32'd0);

        // Saturating instance: down from 0 sticks.
        s_rst = 1'b0;
        s_en = 1'b1;
        s_up = 1'b0;
        tick();
        chk("s_sat0_b", 32'(s_b), 32'd0);
        chk("s_sat0_wr", 32'(s_wrapped), 32'd1);
        s_up = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        chk("s_count7_b", 32'(s_b), 32'd7);
        chk("s_count7_wr", 32'(s_wrapped), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("s_sat_b_%0d", k), 32'(s_b), 32'd7);
            chk($sformatf("s_sat_g_%0d", k), 32'(s_g), 32'b100);
            chk($sformatf("s_sat_wr_%0d", k), 32'(s_wrapped), 32'd1);
        end
        s_up = 1'b0;
        tick();
        chk("s_down_b", 32'(s_b), 32'd6);
        chk("s_down_g", 32'(s_g), 32'b101);
        chk("s_down_wr", 32'(s_wrapped), 32'd0);

        // WIDTH=8 random traffic against a reference model.
        w_rst = 1'b0;
        mb = '0;
        prev_g = '0;
        for (int c = 0; c < 10000; c++) begin
            w_en = 1'($urandom_range(0, 1));
            w_up = 1'($urandom_range(0, 1));
            w_load = ($urandom_range(0, 15) == 0);
            w_load_g = 8'($urandom);
            exp_wr = 1'b0;
            mb_next = mb;
            if (w_load) begin
                mb_next = gray_to_bin8(w_load_g);
            end else if (w_en) begin
                mb_next = w_up ? mb + 8'd1 : mb - 8'd1;
                exp_wr = w_up ? (mb == 8'hff) : (mb == 8'h00);
            end
            tick();
            mb = mb_next;
            chk("w_b", 32'(w_b), 32'(mb));
            chk("w_g", 32'(w_g), 32'(mb ^ (mb >> 1)));
            chk("w_wrapped", 32'(w_wrapped), 32'(exp_wr));
            if (!w_load && w_en) begin
                chk("w_hamming", $countones(w_g ^ prev_g), 32'd1);
            end
            prev_g = w_g;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
